// File: rtl/snn_pkg.sv
// Shared definitions for the spike output path: neuron count, readback
// window register offsets, the outgoing packet layout and the FSM state type.
package snn_pkg;

    localparam int NUM_NEURONS = 256;
    localparam int IDX_W       = 8;
    localparam int CNT_W       = 9;
    localparam int OMEM_WORDS  = 8;

    // Offsets from OMEM_BASE: eight snapshot words then one status word.
    localparam logic [31:0] OMEM_DATA_OFS      = 32'h0000_0000;
    localparam logic [31:0] OMEM_DATA_LAST_OFS = 32'h0000_001C;
    localparam logic [31:0] OMEM_STATUS_OFS    = 32'h0000_0020;

    // Status word bit positions.
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_OVF_BIT  = 1;

    typedef struct packed {
        logic             core_id;
        logic [IDX_W-1:0] index;
    } spike_pkt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } obuf_state_t;

endpackage

// File: rtl/spike_find_first.sv
// Lowest-set-bit finder over the pending spike mask. Purely combinational.
// Ports:
//   spike_vec  in   NUM_NEURONS  vector to search
//   index      out  8            position of the lowest set bit (0 if none)
//   any        out  1            high when at least one bit is set
module spike_find_first #(
    parameter int NUM_NEURONS = snn_pkg::NUM_NEURONS
) (
    input  logic [NUM_NEURONS-1:0]    spike_vec,
    output logic [snn_pkg::IDX_W-1:0] index,
    output logic                      any
);
    import snn_pkg::*;

    // Walking from the top down lets the lowest set bit overwrite last.
    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (spike_vec[i]) begin
                index = IDX_W'(i);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_out_buffer.sv
// Spike output buffer: snapshots the neuron spike vector at the end of each
// timestep, streams one packet per set bit (lowest index first) over a
// valid/ready handshake, and exposes the snapshot plus a status word over a
// Wishbone slave window.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i  Wishbone request (sel ignored, full words)
//   wbs_adr_i, wbs_dat_i        Wishbone address / write data
//   wbs_ack_o, wbs_dat_o        registered acknowledge / read data
//   capture_i                   end-of-timestep strobe
//   spike_neuron_i              spike vector from the neuron core
//   pkt_valid_o/pkt_ready_i     packet handshake
//   pkt_data_o                  packet {core_id, neuron_index}
//   busy_o                      packets still pending
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for capture_i; a capture loads snapshot, mask, count
// SCAN  | presenting lowest pending index; captures here set overflow
module spike_out_buffer #(
    parameter int          NUM_NEURONS = snn_pkg::NUM_NEURONS,
    parameter logic [31:0] OMEM_BASE   = 32'h8004_0000,
    parameter logic        CORE_ID     = 1'b0
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic                   capture_i,
    input  logic [NUM_NEURONS-1:0] spike_neuron_i,
    output logic                   pkt_valid_o,
    input  logic                   pkt_ready_i,
    output logic [8:0]             pkt_data_o,
    output logic                   busy_o
);
    import snn_pkg::*;

    obuf_state_t            state;
    obuf_state_t            state_nxt;
    logic [NUM_NEURONS-1:0] snapshot;
    logic [NUM_NEURONS-1:0] mask;
    logic [CNT_W-1:0]       spike_count;
    logic                   overflow;

    logic [IDX_W-1:0]       first_idx;
    logic                   first_any;
    logic [NUM_NEURONS-1:0] mask_after_accept;
    logic [CNT_W-1:0]       capture_count;
    logic                   scan_active;
    logic                   pkt_accept;
    logic                   capture_idle;
    logic                   capture_scan;

    logic [31:0]            wb_offset;
    logic                   wb_req;
    logic                   wb_is_data;
    logic                   ovf_clear;
    logic [31:0]            rd_data;
    logic [31:0]            status_word;
    logic [OMEM_WORDS*32-1:0] snap_ext;
    logic                   unused_ok;

    spike_find_first #(
        .NUM_NEURONS (NUM_NEURONS)
    ) u_find_first (
        .spike_vec (mask),
        .index     (first_idx),
        .any       (first_any)
    );

    // ---------------- datapath helpers ----------------
    always_comb begin
        capture_count = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            capture_count = capture_count + CNT_W'(spike_neuron_i[i]);
        end
    end

    assign scan_active  = (state == ST_SCAN);
    assign pkt_accept   = scan_active && first_any && pkt_ready_i;
    assign capture_idle = (state == ST_IDLE) && capture_i;
    assign capture_scan = scan_active && capture_i;

    assign mask_after_accept =
        mask & ~({{(NUM_NEURONS-1){1'b0}}, 1'b1} << first_idx);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // An all-zero capture has nothing to send, so stay put.
                if (capture_i && (|spike_neuron_i)) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (pkt_accept && (mask_after_accept == '0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        spike_pkt_t pkt;
        pkt.core_id = CORE_ID;
        pkt.index   = first_idx;
        busy_o      = scan_active;
        pkt_valid_o = scan_active && first_any;
        pkt_data_o  = pkt_valid_o ? pkt : '0;
    end

    // ---------------- snapshot / mask / count / overflow ----------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            snapshot    <= '0;
            mask        <= '0;
            spike_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (capture_idle) begin
                snapshot    <= spike_neuron_i;
                mask        <= spike_neuron_i;
                spike_count <= capture_count;
            end else if (pkt_accept) begin
                mask <= mask_after_accept;
            end

            // A capture that arrives while scanning wins over a software clear.
            if (capture_scan) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // ---------------- Wishbone slave ----------------
    // Subtracting the base makes addresses below it wrap to large offsets,
    // so a single upper-bound compare covers the whole window.
    assign wb_offset  = wbs_adr_i - (OMEM_BASE + OMEM_DATA_OFS);
    assign wb_req     = wbs_cyc_i && wbs_stb_i && !wbs_ack_o &&
                        (wb_offset <= OMEM_STATUS_OFS);
    assign wb_is_data = (wb_offset <= OMEM_DATA_LAST_OFS);
    assign ovf_clear  = wb_req && wbs_we_i &&
                        (wb_offset == OMEM_STATUS_OFS) && wbs_dat_i[STATUS_OVF_BIT];

    always_comb begin
        snap_ext = '0;
        snap_ext[NUM_NEURONS-1:0] = snapshot;
    end

    always_comb begin
        status_word                  = '0;
        status_word[STATUS_BUSY_BIT] = busy_o;
        status_word[STATUS_OVF_BIT]  = overflow;
        status_word[CNT_W+1:2]       = spike_count;
    end

    always_comb begin
        if (wb_is_data) begin
            rd_data = snap_ext[wb_offset[4:2]*32 +: 32];
        end else begin
            rd_data = status_word;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= (wb_req && !wbs_we_i) ? rd_data : '0;
        end
    end

    // Byte selects and the rest of the write data have no function here.
    assign unused_ok = ^{wbs_sel_i, wbs_dat_i[31:2], wbs_dat_i[0]};

endmodule

// File: tb/tb_spike_out_buffer.sv
module tb_spike_out_buffer;

    localparam int          N    = 256;
    localparam logic [31:0] BASE = 32'h8004_0000;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b0;
    logic          wbs_cyc_i = 1'b0;
    logic          wbs_stb_i = 1'b0;
    logic          wbs_we_i = 1'b0;
    logic [3:0]    wbs_sel_i = 4'hF;
    logic [31:0]   wbs_adr_i = '0;
    logic [31:0]   wbs_dat_i = '0;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          capture_i = 1'b0;
    logic [N-1:0]  spike_neuron_i = '0;
    logic          pkt_valid_o;
    logic          pkt_ready_i = 1'b0;
    logic [8:0]    pkt_data_o;
    logic          busy_o;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [8:0]    exp_q[$];

    spike_out_buffer #(
        .NUM_NEURONS (N),
        .OMEM_BASE   (BASE),
        .CORE_ID     (1'b0)
    ) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .wbs_cyc_i      (wbs_cyc_i),
        .wbs_stb_i      (wbs_stb_i),
        .wbs_we_i       (wbs_we_i),
        .wbs_sel_i      (wbs_sel_i),
        .wbs_adr_i      (wbs_adr_i),
        .wbs_dat_i      (wbs_dat_i),
        .wbs_ack_o      (wbs_ack_o),
        .wbs_dat_o      (wbs_dat_o),
        .capture_i      (capture_i),
        .spike_neuron_i (spike_neuron_i),
        .pkt_valid_o    (pkt_valid_o),
        .pkt_ready_i    (pkt_ready_i),
        .pkt_data_o     (pkt_data_o),
        .busy_o         (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic push_expected(input logic [N-1:0] vec);
        for (int i = 0; i < N; i++) begin
            if (vec[i]) exp_q.push_back({1'b0, 8'(i)});
        end
    endtask

    task automatic capture(input logic [N-1:0] vec);
        spike_neuron_i = vec;
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat, output bit acked);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = adr;
        acked = 1'b0; dat = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            tick();
            if (wbs_ack_o) begin acked = 1'b1; dat = wbs_dat_o; end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, output bit acked);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = adr; wbs_dat_i = dat;
        acked = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            tick();
            if (wbs_ack_o) acked = 1'b1;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    // Pops the scoreboard on every handshake; ready is constant-high or random.
    task automatic drain(input int budget, input bit rand_ready, output int cycles);
        logic [8:0] exp;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < budget) begin
            pkt_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pkt_valid_o && pkt_ready_i) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (pkt_data_o !== exp) begin
                    n_fail++;
                    $display("FAIL pkt_order: got %h want %h", pkt_data_o, exp);
                end
            end
            tick();
            cycles++;
        end
        pkt_ready_i = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d packets missing after %0d cycles", exp_q.size(), cycles);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d; bit a;
        wb_rst_i = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({pkt_valid_o, busy_o, wbs_ack_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got valid/busy/ack %b want 000", {pkt_valid_o, busy_o, wbs_ack_o});
        end
        n_checks++;
        if (pkt_data_o !== 9'h000 || wbs_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got pkt %h dat %h want 0 0", pkt_data_o, wbs_dat_o);
        end
        wb_rst_i = 1'b1;
        tick();
        wb_read(BASE + 32'h20, d, a);
        n_checks++;
        if (!a || d !== 32'h0) begin
            n_fail++; $display("FAIL reset_status: got ack %0d dat %h want 1 0", a, d);
        end
    endtask

    task automatic test_ready_high();
        logic [N-1:0] vec; int cyc;
        vec = '0; vec[3] = 1'b1; vec[200] = 1'b1; vec[255] = 1'b1;
        pkt_ready_i = 1'b1;
        push_expected(vec);
        capture(vec);
        n_checks++;
        if (pkt_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL first_pkt_latency: got valid %b busy %b want 1 1", pkt_valid_o, busy_o);
        end
        drain(20, 1'b0, cyc);
        n_checks++;
        if (cyc !== 3) begin
            n_fail++; $display("FAIL throughput: got %0d cycles want 3", cyc);
        end
        n_checks++;
        if (busy_o !== 1'b0 || pkt_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL scan_done: got busy %b valid %b want 0 0", busy_o, pkt_valid_o);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] vec; int cyc; int bad;
        vec = '0; vec[3] = 1'b1; vec[200] = 1'b1; vec[255] = 1'b1;
        pkt_ready_i = 1'b0;
        push_expected(vec);
        capture(vec);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (pkt_valid_o !== 1'b1 || pkt_data_o !== 9'h003) begin
                n_fail++; bad++;
                $display("FAIL stall_hold cycle %0d: got valid %b data %h want 1 003", i, pkt_valid_o, pkt_data_o);
            end
            tick();
        end
        drain(20, 1'b0, cyc);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_done: got busy %b want 0", busy_o);
        end
    endtask

    task automatic test_zero_capture();
        logic [31:0] d; bit a;
        capture('0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (pkt_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL zero_idle cycle %0d: got valid %b busy %b want 0 0", i, pkt_valid_o, busy_o);
            end
            tick();
        end
        wb_read(BASE + 32'h20, d, a);
        n_checks++;
        if (!a || d !== 32'h0) begin
            n_fail++; $display("FAIL zero_status: got ack %0d dat %h want 1 0", a, d);
        end
        wb_read(BASE + 32'h18, d, a);
        n_checks++;
        if (!a || d !== 32'h0) begin
            n_fail++; $display("FAIL zero_snapshot: got ack %0d dat %h want 1 0", a, d);
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] vec; logic [N-1:0] other; logic [31:0] d; bit a; int cyc;
        vec = '0; vec[3] = 1'b1; vec[200] = 1'b1; vec[255] = 1'b1;
        other = '0; other[7] = 1'b1; other[100] = 1'b1;
        pkt_ready_i = 1'b0;
        push_expected(vec);
        capture(vec);
        capture(other);
        wb_read(BASE + 32'h20, d, a);
        n_checks++;
        if (!a || d !== 32'h0000_000F) begin
            n_fail++; $display("FAIL ovf_set: got ack %0d dat %h want 1 0000000f", a, d);
        end
        wb_write(BASE + 32'h20, 32'h2, a);
        wb_read(BASE + 32'h20, d, a);
        n_checks++;
        if (!a || d !== 32'h0000_000D) begin
            n_fail++; $display("FAIL ovf_clear: got ack %0d dat %h want 1 0000000d", a, d);
        end
        // clear write and capture land on the same edge
        capture_i = 1'b1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = BASE + 32'h20; wbs_dat_i = 32'h2;
        tick();
        capture_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wb_read(BASE + 32'h20, d, a);
        n_checks++;
        if (!a || d[1] !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set_wins: got ack %0d dat %h want bit1 set", a, d);
        end
        wb_write(BASE + 32'h20, 32'h2, a);
        wb_read(BASE + 32'h00, d, a);
        n_checks++;
        if (!a || d !== 32'h0000_0008) begin
            n_fail++; $display("FAIL ovf_snap_w0: got ack %0d dat %h want 1 00000008", a, d);
        end
        wb_read(BASE + 32'h18, d, a);
        n_checks++;
        if (!a || d !== 32'h0000_0100) begin
            n_fail++; $display("FAIL ovf_snap_w6: got ack %0d dat %h want 1 00000100", a, d);
        end
        drain(50, 1'b1, cyc);
        wb_read(BASE + 32'h20, d, a);
        n_checks++;
        if (!a || d !== 32'h0000_000C) begin
            n_fail++; $display("FAIL ovf_after: got ack %0d dat %h want 1 0000000c", a, d);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] vec; logic [31:0] d; bit a; int cyc; int k;
        for (int r = 0; r < 3; r++) begin
            vec = '0;
            for (int i = 0; i < N; i++) vec[i] = ($urandom_range(0, 15) == 0);
            vec[$urandom_range(0, N - 1)] = 1'b1;
            pkt_ready_i = 1'b0;
            push_expected(vec);
            capture(vec);
            k = $urandom_range(0, 7);
            wb_read(BASE + 32'(k * 4), d, a);
            n_checks++;
            if (!a || d !== vec[k*32 +: 32]) begin
                n_fail++; $display("FAIL rand_snap word %0d: got ack %0d dat %h want %h", k, a, d, vec[k*32 +: 32]);
            end
            drain(3000, 1'b1, cyc);
            n_checks++;
            if (busy_o !== 1'b0) begin
                n_fail++; $display("FAIL rand_done: got busy %b want 0", busy_o);
            end
        end
    endtask

    task automatic test_full();
        logic [N-1:0] vec; logic [31:0] d; bit a; int cyc;
        vec = '1;
        pkt_ready_i = 1'b0;
        push_expected(vec);
        capture(vec);
        wb_read(BASE + 32'h20, d, a);
        n_checks++;
        if (!a || d !== 32'h0000_0401) begin
            n_fail++; $display("FAIL full_status: got ack %0d dat %h want 1 00000401", a, d);
        end
        wb_read(BASE + 32'h1C, d, a);
        n_checks++;
        if (!a || d !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL full_w7: got ack %0d dat %h want 1 ffffffff", a, d);
        end
        wb_read(BASE + 32'h40, d, a);
        n_checks++;
        if (a) begin
            n_fail++; $display("FAIL noack_0x40: got ack 1 want 0");
        end
        wb_read(BASE + 32'h24, d, a);
        n_checks++;
        if (a) begin
            n_fail++; $display("FAIL noack_0x24: got ack 1 want 0");
        end
        wb_read(BASE - 32'h4, d, a);
        n_checks++;
        if (a) begin
            n_fail++; $display("FAIL noack_below: got ack 1 want 0");
        end
        wb_write(BASE + 32'h00, 32'h0, a);
        n_checks++;
        if (!a) begin
            n_fail++; $display("FAIL data_write_ack: got ack 0 want 1");
        end
        wb_read(BASE + 32'h00, d, a);
        n_checks++;
        if (!a || d !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL data_write_ignored: got ack %0d dat %h want 1 ffffffff", a, d);
        end
        drain(400, 1'b0, cyc);
        n_checks++;
        if (cyc !== 256 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL full_drain: got %0d cycles busy %b want 256 0", cyc, busy_o);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [N-1:0] vec; logic [31:0] d; bit a; int seen;
        vec = '0; vec[3] = 1'b1; vec[200] = 1'b1; vec[255] = 1'b1;
        pkt_ready_i = 1'b1;
        capture(vec);
        n_checks++;
        if (pkt_data_o !== 9'h003) begin
            n_fail++; $display("FAIL mid_pkt0: got %h want 003", pkt_data_o);
        end
        tick();
        n_checks++;
        if (pkt_data_o !== 9'h0C8) begin
            n_fail++; $display("FAIL mid_pkt1: got %h want 0c8", pkt_data_o);
        end
        tick();
        pkt_ready_i = 1'b0;
        wb_rst_i = 1'b0;
        tick();
        n_checks++;
        if ({pkt_valid_o, busy_o, wbs_ack_o} !== 3'b000 || pkt_data_o !== 9'h0 || wbs_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got v/b/a %b pkt %h dat %h want 000 0 0",
                               {pkt_valid_o, busy_o, wbs_ack_o}, pkt_data_o, wbs_dat_o);
        end
        tick();
        wb_rst_i = 1'b1;
        pkt_ready_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (pkt_valid_o !== 1'b0) seen++;
            tick();
        end
        pkt_ready_i = 1'b0;
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL mid_no_packet: got valid on %0d cycles want 0", seen);
        end
        wb_read(BASE + 32'h20, d, a);
        n_checks++;
        if (!a || d !== 32'h0) begin
            n_fail++; $display("FAIL mid_status: got ack %0d dat %h want 1 0", a, d);
        end
        wb_read(BASE + 32'h1C, d, a);
        n_checks++;
        if (!a || d !== 32'h0) begin
            n_fail++; $display("FAIL mid_snapshot: got ack %0d dat %h want 1 0", a, d);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_ready_high();
        test_backpressure();
        test_zero_capture();
        test_overflow();
        test_random();
        test_full();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_out_buffer.md
SPIKE_OUT_BUFFER -- requirements
Module: spike_out_buffer

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 256, meaning the width of the captured spike vector.
REQ-002 The block SHALL have parameter OMEM_BASE, default 32'h80040000, meaning the Wishbone base address of the readback window.
REQ-003 The block SHALL have parameter CORE_ID, default 1'b0, meaning the core tag placed in every packet.
REQ-004 wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 wb_rst_i  input  1  synchronous, active-low reset.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone cycle, strobe, write-enable.
REQ-007 wbs_sel_i  input  4  byte selects; ignored (full-word access only).
REQ-008 wbs_adr_i, wbs_dat_i  input  32 each  Wishbone address, write data.
REQ-009 wbs_ack_o  output  1; wbs_dat_o  output  32  Wishbone acknowledge, read data.
REQ-010 capture_i  input  1  single-cycle strobe marking end of a timestep.
REQ-011 spike_neuron_i  input  NUM_NEURONS  spike vector from the neuron core.
REQ-012 pkt_valid_o  output  1; pkt_ready_i  input  1  downstream packet handshake.
REQ-013 pkt_data_o  output  9  packet {CORE_ID, neuron_index[7:0]}.
REQ-014 busy_o  output  1  high while packets remain to be sent.

Function
REQ-015 FSM SHALL have states IDLE and SCAN; busy_o SHALL equal (state == SCAN).
REQ-016 In IDLE, capture_i SHALL latch spike_neuron_i into both snapshot register and pending mask, and load spike_count with its popcount (9 bits, 0..256).
REQ-017 A capture with non-zero vector SHALL move to SCAN on the next edge; an all-zero capture SHALL stay IDLE, update snapshot and set spike_count to 0.
REQ-018 In SCAN, pkt_valid_o SHALL be high and pkt_data_o SHALL carry the lowest-indexed set bit of the pending mask; first packet appears 1 cycle after capture_i.
REQ-019 On pkt_valid_o & pkt_ready_i, that mask bit SHALL clear; the next packet SHALL be presented the following cycle (throughput 1 packet/cycle).
REQ-020 pkt_data_o SHALL remain stable while pkt_valid_o is high and pkt_ready_i is low.
REQ-021 When the last set bit is accepted, FSM SHALL return to IDLE and pkt_valid_o SHALL drop on the next cycle.
REQ-022 capture_i while in SCAN SHALL be ignored (snapshot, mask unchanged) and SHALL set sticky overflow flag.
REQ-023 Wishbone read at OMEM_BASE + 4*k, k = 0..7, SHALL return snapshot bits [32k+31:32k].
REQ-024 Wishbone read at OMEM_BASE + 0x20 SHALL return {21'b0, spike_count[8:0], overflow, busy}.
REQ-025 Wishbone write to OMEM_BASE + 0x20 with wbs_dat_i[1] = 1 SHALL clear overflow; writes elsewhere SHALL be acked and ignored.
REQ-026 overflow set and clear in the same cycle: set SHALL win.
REQ-027 wbs_ack_o SHALL be registered, asserted for exactly one cycle when cyc & stb & address in [OMEM_BASE, OMEM_BASE+0x20] & !wbs_ack_o; out-of-range addresses SHALL receive no ack.
REQ-028 wbs_dat_o SHALL be 0 when wbs_ack_o is low.

Reset
REQ-029 While wb_rst_i is low at a clock edge: state = IDLE, snapshot = 0, mask = 0, spike_count = 0, overflow = 0, pkt_valid_o = 0, pkt_data_o = 0, wbs_ack_o = 0, wbs_dat_o = 0.
REQ-030 Reset asserted mid-SCAN SHALL abandon remaining packets; no packet SHALL be emitted after reset release until a new capture.

Structure
REQ-031 Shared package snn_pkg SHALL hold NUM_NEURONS, OMEM register offsets (0x00-0x1C data, 0x20 status), spike_pkt_t typedef {core_id, index} and the FSM state enum.
REQ-032 Lowest-set-bit search SHALL be a sub-module spike_find_first (NUM_NEURONS-bit input, 8-bit index, 1-bit any output), purely combinational.

Verification
REQ-033 Capture vector with bits 3, 200, 255 set, pkt_ready_i held high -> packets 0x003, 0x0C8, 0x0FF on three consecutive cycles starting 1 cycle after capture, then busy_o low.
REQ-034 Same vector, pkt_ready_i low for 5 cycles -> pkt_data_o held at 0x003 with valid high for all 5 cycles; order unchanged afterwards.
REQ-035 All-zero capture -> no pkt_valid_o, busy_o stays 0, status read returns 0x0.
REQ-036 Second capture_i during SCAN -> ignored, status bit1 = 1; write 0x2 to offset 0x20 -> bit1 reads 0.
REQ-037 All 256 bits set, capture, read offset 0x20 -> spike_count = 256, busy = 1; read offset 0x1C -> 0xFFFFFFFF; address OMEM_BASE+0x40 -> no ack.
REQ-038 Assert reset after 2 of 3 packets accepted -> third packet never appears; all outputs read 0.
